// File: rtl/move_exec_pkg.sv
// Shared definitions for the move execute stage: data width and FSM state encodings.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package move_exec_pkg;

  localparam int DATA_WIDTH = `DATA_WIDTH;

  typedef enum logic [1:0] {
    MX_IDLE     = 2'd0,
    MX_READ     = 2'd1,
    MX_WAIT_TGT = 2'd2,
    MX_WRITE    = 2'd3
  } mx_state_t;

endpackage

// File: rtl/move_exec_if.sv
// Fetch-side pair handshake plus device bus signals of the move execute stage.
// The master view belongs to move_exec; the slave view to its environment.
interface move_exec_if #(
  parameter int DW = 8
);

  logic          i_valid;
  logic          i_target_flag;
  logic [DW-1:0] i_device;
  logic [DW-1:0] i_address;
  logic          o_ready;
  logic          o_bus_req;
  logic          o_bus_we;
  logic [DW-1:0] o_bus_device;
  logic [DW-1:0] o_bus_address;
  logic [DW-1:0] o_bus_wdata;
  logic          i_bus_ack;
  logic [DW-1:0] i_bus_rdata;
  logic          o_done;
  logic          o_error;

  modport master (
    input  i_valid, i_target_flag, i_device, i_address, i_bus_ack, i_bus_rdata,
    output o_ready, o_bus_req, o_bus_we, o_bus_device, o_bus_address, o_bus_wdata,
    output o_done, o_error
  );

  modport slave (
    output i_valid, i_target_flag, i_device, i_address, i_bus_ack, i_bus_rdata,
    input  o_ready, o_bus_req, o_bus_we, o_bus_device, o_bus_address, o_bus_wdata,
    input  o_done, o_error
  );

endinterface

// File: rtl/move_exec_ack_timer.sv
// Counts cycles a bus request has waited without acknowledge; flags expiry on
// the last allowed waiting cycle. ACK_TIMEOUT of 0 never expires.
module move_exec_ack_timer #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] LAST = (ACK_TIMEOUT > 0) ? TW'(ACK_TIMEOUT - 1) : '0;

  logic [TW-1:0] count;

  // Held at zero while not waiting, advances once per unacknowledged cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (ACK_TIMEOUT > 0) && enable && (count == LAST);

endmodule

// File: rtl/move_exec.sv
// Move execute stage: reads one word from the source (device,address) and
// writes it to the target (device,address) supplied by the fetch stage.
module move_exec
  import move_exec_pkg::*;
#(
  parameter int DATA_WIDTH  = move_exec_pkg::DATA_WIDTH,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  move_exec_if.master   bus
);

  mx_state_t             state;
  logic [DATA_WIDTH-1:0] src_device;
  logic [DATA_WIDTH-1:0] src_address;
  logic [DATA_WIDTH-1:0] tgt_device;
  logic [DATA_WIDTH-1:0] tgt_address;
  logic [DATA_WIDTH-1:0] data_word;
  logic                  done_q;
  logic                  error_q;
  logic                  busy;
  logic                  expire;

  assign busy = (state == MX_READ) || (state == MX_WRITE);

  move_exec_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (!busy),
    .enable (busy && !bus.i_bus_ack),
    .expire (expire)
  );

  // Sequencing of source read and target write, with one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= MX_IDLE;
      src_device  <= '0;
      src_address <= '0;
      tgt_device  <= '0;
      tgt_address <= '0;
      data_word   <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state)
        MX_IDLE: begin
          if (bus.i_valid) begin
            if (!bus.i_target_flag) begin
              src_device  <= bus.i_device;
              src_address <= bus.i_address;
              state       <= MX_READ;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        MX_READ: begin
          if (bus.i_bus_ack) begin
            data_word <= bus.i_bus_rdata;
            state     <= MX_WAIT_TGT;
          end else if (expire) begin
            error_q <= 1'b1;
            state   <= MX_IDLE;
          end
        end
        MX_WAIT_TGT: begin
          if (bus.i_valid) begin
            if (bus.i_target_flag) begin
              tgt_device  <= bus.i_device;
              tgt_address <= bus.i_address;
              state       <= MX_WRITE;
            end else begin
              src_device  <= bus.i_device;
              src_address <= bus.i_address;
              data_word   <= '0;
              error_q     <= 1'b1;
              state       <= MX_READ;
            end
          end
        end
        MX_WRITE: begin
          if (bus.i_bus_ack) begin
            done_q <= 1'b1;
            state  <= MX_IDLE;
          end else if (expire) begin
            error_q <= 1'b1;
            state   <= MX_IDLE;
          end
        end
        default: state <= MX_IDLE;
      endcase
    end
  end

  assign bus.o_ready       = (state == MX_IDLE) || (state == MX_WAIT_TGT);
  assign bus.o_bus_req     = busy;
  assign bus.o_bus_we      = (state == MX_WRITE);
  assign bus.o_bus_device  = (state == MX_WRITE) ? tgt_device :
                             (state == MX_READ)  ? src_device  : '0;
  assign bus.o_bus_address = (state == MX_WRITE) ? tgt_address :
                             (state == MX_READ)  ? src_address : '0;
  assign bus.o_bus_wdata   = data_word;
  assign bus.o_done        = done_q;
  assign bus.o_error       = error_q;

endmodule

// File: tb/tb_move_exec.sv
// Directed bench for move_exec: a vector table for the basic move, stray
// target and source-replacement cases, then hand sequences for delayed ack,
// reset during write and the short-timeout instance.
module tb_move_exec;

  logic       clk;
  logic       rst_n;
  logic       valid;
  logic       tgt;
  logic [7:0] dev;
  logic [7:0] addr;
  logic       ack;
  logic [7:0] rdata;

  int compared   = 0;
  int mismatched = 0;

  move_exec_if #(.DW(8)) mif ();
  move_exec_if #(.DW(8)) tif ();

  assign mif.i_valid       = valid;
  assign mif.i_target_flag = tgt;
  assign mif.i_device      = dev;
  assign mif.i_address     = addr;
  assign mif.i_bus_ack     = ack;
  assign mif.i_bus_rdata   = rdata;
  assign tif.i_valid       = valid;
  assign tif.i_target_flag = tgt;
  assign tif.i_device      = dev;
  assign tif.i_address     = addr;
  assign tif.i_bus_ack     = ack;
  assign tif.i_bus_rdata   = rdata;

  move_exec #(.DATA_WIDTH(8), .ACK_TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif)
  );

  move_exec #(.DATA_WIDTH(8), .ACK_TIMEOUT(4)) dut_short (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        t;
    logic [7:0]  d;
    logic [7:0]  a;
    logic        k;
    logic [7:0]  rd;
    logic [28:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [28:0] e(input logic rdy, input logic req, input logic we,
                                     input logic dn, input logic er, input logic [7:0] bd,
                                     input logic [7:0] ba, input logic [7:0] wd);
    return {rdy, req, we, dn, er, bd, ba, wd};
  endfunction

  function automatic vec_t mk(input logic v, input logic t, input logic [7:0] d,
                              input logic [7:0] a, input logic k, input logic [7:0] rd,
                              input logic [28:0] x);
    vec_t r;
    r.v = v; r.t = t; r.d = d; r.a = a; r.k = k; r.rd = rd; r.exp = x;
    return r;
  endfunction

  function automatic logic [28:0] packMain();
    return {mif.o_ready, mif.o_bus_req, mif.o_bus_we, mif.o_done, mif.o_error,
            mif.o_bus_device, mif.o_bus_address, mif.o_bus_wdata};
  endfunction

  function automatic logic [28:0] packShort();
    return {tif.o_ready, tif.o_bus_req, tif.o_bus_we, tif.o_done, tif.o_error,
            tif.o_bus_device, tif.o_bus_address, tif.o_bus_wdata};
  endfunction

  task automatic applyStimulus(input logic v, input logic t, input logic [7:0] d,
                               input logic [7:0] a, input logic k, input logic [7:0] rd);
    valid = v; tgt = t; dev = d; addr = a; ack = k; rdata = rd;
  endtask

  task automatic checkOutput(input string name, input logic [28:0] got, input logic [28:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s got {rdy,req,we,done,err,dev,addr,wdata}=%b_%h_%h_%h expected %b_%h_%h_%h",
               name, got[28:24], got[23:16], got[15:8], got[7:0],
               want[28:24], want[23:16], want[15:8], want[7:0]);
    end
  endtask

  // Apply inputs for one cycle, sample mid-cycle, then advance past the edge.
  task automatic stepCheck(input string name, input logic use_short, input logic [28:0] want);
    @(negedge clk);
    checkOutput(name, use_short ? packShort() : packMain(), want);
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 8'h00);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_main", packMain(), e(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    checkOutput("reset_short", packShort(), e(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic move, stray target in IDLE, source replacement, ack outside transfer.
    vecs.push_back(mk(1, 0, 8'h03, 8'h10, 0, 8'h00, e(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00)));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'hA5, e(0, 1, 0, 0, 0, 8'h03, 8'h10, 8'h00)));
    vecs.push_back(mk(1, 1, 8'h05, 8'h20, 0, 8'h00, e(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'hA5)));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'h00, e(0, 1, 1, 0, 0, 8'h05, 8'h20, 8'hA5)));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h00, e(1, 0, 0, 1, 0, 8'h00, 8'h00, 8'hA5)));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h00, e(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'hA5)));
    vecs.push_back(mk(1, 1, 8'h07, 8'h33, 0, 8'h00, e(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'hA5)));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h00, e(1, 0, 0, 0, 1, 8'h00, 8'h00, 8'hA5)));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h00, e(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'hA5)));
    vecs.push_back(mk(1, 0, 8'h01, 8'h01, 0, 8'h00, e(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'hA5)));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'h3C, e(0, 1, 0, 0, 0, 8'h01, 8'h01, 8'hA5)));
    vecs.push_back(mk(1, 0, 8'h02, 8'h02, 0, 8'h00, e(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h3C)));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h00, e(0, 1, 0, 0, 1, 8'h02, 8'h02, 8'h00)));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'h77, e(0, 1, 0, 0, 0, 8'h02, 8'h02, 8'h00)));
    vecs.push_back(mk(1, 1, 8'h04, 8'h44, 0, 8'h00, e(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h77)));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'h00, e(0, 1, 1, 0, 0, 8'h04, 8'h44, 8'h77)));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h00, e(1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h77)));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'hFF, e(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h77)));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h00, e(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h77)));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].v, vecs[i].t, vecs[i].d, vecs[i].a, vecs[i].k, vecs[i].rd);
      stepCheck($sformatf("vec%0d", i), 1'b0, vecs[i].exp);
    end

    // Read ack delayed by 5 cycles: bus fields stay put, fetch stays blocked.
    applyStimulus(1, 0, 8'h06, 8'h61, 0, 8'h00);
    stepCheck("slow_src", 1'b0, e(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h77));
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 8'h00, 8'h00, 0, 8'h00);
      stepCheck($sformatf("slow_wait%0d", i), 1'b0, e(0, 1, 0, 0, 0, 8'h06, 8'h61, 8'h77));
    end
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 8'h5A);
    stepCheck("slow_ack", 1'b0, e(0, 1, 0, 0, 0, 8'h06, 8'h61, 8'h77));

    // Reset while the write waits for ack.
    applyStimulus(1, 1, 8'h09, 8'h90, 0, 8'h00);
    stepCheck("rst_tgt", 1'b0, e(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h5A));
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 8'h00);
    stepCheck("rst_write", 1'b0, e(0, 1, 1, 0, 0, 8'h09, 8'h90, 8'h5A));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async", packMain(), e(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      stepCheck($sformatf("rst_hold%0d", i), 1'b0, e(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    end
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      stepCheck($sformatf("rst_after%0d", i), 1'b0, e(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    end

    // Short-timeout instance: no ack gives exactly 4 request cycles then error.
    applyStimulus(1, 0, 8'h01, 8'h11, 0, 8'h00);
    stepCheck("to_src", 1'b1, e(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      stepCheck($sformatf("to_req%0d", i), 1'b1, e(0, 1, 0, 0, 0, 8'h01, 8'h11, 8'h00));
    end
    stepCheck("to_err", 1'b1, e(1, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00));
    stepCheck("to_idle", 1'b1, e(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00));

    // Ack on the last allowed cycle wins, for both read and write.
    applyStimulus(1, 0, 8'h02, 8'h22, 0, 8'h00);
    stepCheck("late_src", 1'b1, e(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00));
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      stepCheck($sformatf("late_rd%0d", i), 1'b1, e(0, 1, 0, 0, 0, 8'h02, 8'h22, 8'h00));
    end
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 8'hC3);
    stepCheck("late_rd_ack", 1'b1, e(0, 1, 0, 0, 0, 8'h02, 8'h22, 8'h00));
    applyStimulus(1, 1, 8'h03, 8'h33, 0, 8'h00);
    stepCheck("late_tgt", 1'b1, e(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'hC3));
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      stepCheck($sformatf("late_wr%0d", i), 1'b1, e(0, 1, 1, 0, 0, 8'h03, 8'h33, 8'hC3));
    end
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 8'h00);
    stepCheck("late_wr_ack", 1'b1, e(0, 1, 1, 0, 0, 8'h03, 8'h33, 8'hC3));
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 8'h00);
    stepCheck("late_done", 1'b1, e(1, 0, 0, 1, 0, 8'h00, 8'h00, 8'hC3));
    stepCheck("late_quiet", 1'b1, e(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'hC3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
